// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, single-outstanding imem reads and a
// 2-entry {instr, pc} buffer to the decoder; redirects flush all of it.
module instr_fetch #(
  parameter int                ISIZE    = 32,
  parameter int                PCSIZE   = 32,
  parameter logic [PCSIZE-1:0] RESET_PC = '0,
  parameter logic [ISIZE-1:0]  NOP      = ISIZE'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PCSIZE-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [ISIZE-1:0]  imem_rdata,
  output logic [ISIZE-1:0]  instr,
  output logic [PCSIZE-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [PCSIZE-1:0] redirect_pc
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t              r_state, w_state;
  logic [PCSIZE-1:0]   r_pc, w_pc;
  logic                r_req;
  logic                r_vld;
  logic [1:0]          r_cnt, w_cnt;
  logic [ISIZE-1:0]    r_i0, r_i1, w_i0, w_i1;
  logic [PCSIZE-1:0]   r_p0, r_p1, w_p0, w_p1;
  logic                w_pop;
  logic                w_push;
  logic [PCSIZE-1:0]   w_ipc;

  assign w_pop  = r_vld & instr_ready & ~redirect_valid;
  assign w_push = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;
  // fetch_pc has already advanced past the in-flight read
  assign w_ipc  = r_pc - PCSIZE'(4);

  // Slot 0 is the head; unused slots are held at {NOP, 0}
  always_comb begin
    w_i0  = r_i0;
    w_p0  = r_p0;
    w_i1  = r_i1;
    w_p1  = r_p1;
    w_cnt = r_cnt;
    if (redirect_valid) begin
      w_i0  = NOP;
      w_p0  = '0;
      w_i1  = NOP;
      w_p1  = '0;
      w_cnt = 2'd0;
    end else begin
      if (w_pop) begin
        w_i0  = r_i1;
        w_p0  = r_p1;
        w_i1  = NOP;
        w_p1  = '0;
        w_cnt = r_cnt - 2'd1;
      end
      if (w_push) begin
        if (w_cnt == 2'd0) begin
          w_i0 = imem_rdata;
          w_p0 = w_ipc;
        end else begin
          w_i1 = imem_rdata;
          w_p1 = w_ipc;
        end
        w_cnt = w_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    case (r_state)
      S_IDLE: w_state = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          w_state = S_WAIT;
          w_pc    = r_pc + PCSIZE'(4);
        end
      end
      S_WAIT: if (imem_rvalid) w_state = (w_cnt < 2'd2) ? S_REQ : S_HOLD;
      S_HOLD: if (w_cnt < 2'd2) w_state = S_REQ;
      S_DROP: if (imem_rvalid) w_state = S_REQ;
      default: w_state = S_IDLE;
    endcase
    // Redirect overrides; a read already granted must be drained in DROP
    if (redirect_valid) begin
      w_pc = redirect_pc & ~PCSIZE'(3);
      case (r_state)
        S_REQ:          w_state = imem_gnt ? S_DROP : S_REQ;
        S_WAIT, S_DROP: w_state = imem_rvalid ? S_REQ : S_DROP;
        default:        w_state = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_vld   <= 1'b0;
      r_cnt   <= 2'd0;
      r_i0    <= NOP;
      r_p0    <= '0;
      r_i1    <= NOP;
      r_p1    <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_req   <= (w_state == S_REQ);
      r_vld   <= (w_cnt != 2'd0);
      r_cnt   <= w_cnt;
      r_i0    <= w_i0;
      r_p0    <= w_p0;
      r_i1    <= w_i1;
      r_p1    <= w_p1;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_i0;
  assign instr_pc    = r_p0;
  assign instr_valid = r_vld;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random-latency memory, scoreboard of expected
// sequential PCs restarted on reset/redirect, plus directed scenarios.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch #(.ISIZE(32), .PCSIZE(32), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int g_prob   = 100;
  int lat_min  = 1;
  int lat_max  = 1;
  bit mem_pend = 1'b0;
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, RESET_PC);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_pc"},    instr_pc, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  // Memory: grants randomly, returns data 'lat' cycles after the grant
  initial begin : mem
    bit          gnt_was;
    logic [31:0] gaddr, paddr;
    int          cnt;
    gnt_was = 1'b0; gaddr = '0; paddr = '0; cnt = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (gnt_was) begin
        mem_pend = 1'b1;
        paddr    = gaddr;
        cnt      = int'($urandom_range(lat_max, lat_min));
        gnt_log.push_back(gaddr);
      end
      gnt_was     = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memfn(paddr);
          mem_pend    = 1'b0;
        end
      end
      if (imem_req && !mem_pend && (int'($urandom_range(99, 0)) < g_prob)) begin
        imem_gnt = 1'b1;
        gnt_was  = 1'b1;
        gaddr    = imem_addr;
      end
    end
  end

  // Monitor/scoreboard: expected stream is consecutive PCs from the last restart
  initial begin : mon
    logic [31:0] q[$];
    logic [31:0] e, p_addr, p_rpc;
    logic        p_req, p_gnt, p_rd, p_rst;
    p_req = 0; p_gnt = 0; p_rd = 0; p_rst = 0; p_addr = '0; p_rpc = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst && p_rst) begin
        if (p_req && !p_gnt && !p_rd) begin
          chk("req_held", {31'd0, imem_req}, 32'd1);
          chk("addr_stable", imem_addr, p_addr);
        end
        if (p_rd) begin
          chk("redir_valid_drop", {31'd0, instr_valid}, 32'd0);
          chk("redir_addr", imem_addr, p_rpc & ~32'h3);
        end
      end
      if (rst && !instr_valid) begin
        chk("empty_instr", instr, NOP);
        chk("empty_pc", instr_pc, 32'd0);
      end
      if (!rst) begin
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(RESET_PC + 32'(4 * i));
      end else if (redirect_valid) begin
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back((redirect_pc & ~32'h3) + 32'(4 * i));
      end else if (instr_valid && instr_ready) begin
        e = q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_instr", instr, memfn(e));
        pop_log.push_back(instr_pc);
        q.push_back(q[$] + 32'd4);
      end
      p_req = imem_req; p_gnt = imem_gnt; p_rd = redirect_valid;
      p_rst = rst; p_addr = imem_addr; p_rpc = redirect_pc;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g, n, n0;
    rst = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) step();
    chk_reset_vals("rst");
    rst = 1'b1;
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);

    // Immediate grant, 1-cycle data
    for (int i = 0; i < 40 && (gnt_log.size() < 3 || pop_log.size() < 2); i++) step();
    chk("t1_wait", {31'd0, (gnt_log.size() >= 3 && pop_log.size() >= 2)}, 32'd1);
    if (gnt_log.size() >= 3) begin
      chk("t1_addr0", gnt_log[0], 32'h0);
      chk("t1_addr1", gnt_log[1], 32'h4);
      chk("t1_addr2", gnt_log[2], 32'h8);
    end
    if (pop_log.size() >= 2) begin
      chk("t1_pc0", pop_log[0], 32'h0);
      chk("t1_pc1", pop_log[1], 32'h4);
    end
    n0 = pop_log.size();
    repeat (20) step();
    chk("t1_throughput", 32'(pop_log.size() - n0), 32'd10);

    // Back-pressure with buffer full
    instr_ready = 1'b0;
    do_redirect(32'h0);
    repeat (15) step();
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_head_pc", instr_pc, 32'h0);
    g = gnt_log.size();
    repeat (5) begin
      step();
      chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    end
    chk("t2_no_gnt", 32'(gnt_log.size() - g), 32'd0);
    n = pop_log.size();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && (pop_log.size() < n + 2 || gnt_log.size() <= g); i++) step();
    chk("t2_wait", {31'd0, (pop_log.size() >= n + 2 && gnt_log.size() > g)}, 32'd1);
    if (pop_log.size() >= n + 2) begin
      chk("t2_pc0", pop_log[n], 32'h0);
      chk("t2_pc1", pop_log[n+1], 32'h4);
    end
    if (gnt_log.size() > g) chk("t2_resume", gnt_log[g], 32'h8);

    // Redirect while waiting for data, then redirect with a grant
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && !(mem_pend && !imem_rvalid); i++) step();
    chk("t3_wait_pend", {31'd0, (mem_pend && !imem_rvalid)}, 32'd1);
    do_redirect(32'h103);
    g = gnt_log.size(); n = pop_log.size();
    for (int i = 0; i < 40 && (gnt_log.size() <= g || pop_log.size() <= n); i++) step();
    chk("t3_wait", {31'd0, (gnt_log.size() > g && pop_log.size() > n)}, 32'd1);
    if (gnt_log.size() > g) chk("t3_addr", gnt_log[g], 32'h100);
    if (pop_log.size() > n) chk("t3_pc", pop_log[n], 32'h100);

    for (int i = 0; i < 40 && !imem_gnt; i++) step();
    chk("t4_wait_gnt", {31'd0, imem_gnt}, 32'd1);
    do_redirect(32'h200);
    g = gnt_log.size(); n = pop_log.size();
    for (int i = 0; i < 40 && (gnt_log.size() <= g || pop_log.size() <= n); i++) step();
    chk("t4_wait", {31'd0, (gnt_log.size() > g && pop_log.size() > n)}, 32'd1);
    if (gnt_log.size() > g) chk("t4_addr", gnt_log[g], 32'h200);
    if (pop_log.size() > n) chk("t4_pc", pop_log[n], 32'h200);

    // Redirect coinciding with pop and rvalid, one entry buffered
    lat_min = 2; lat_max = 2;
    instr_ready = 1'b0;
    do_redirect(32'h300);
    for (int i = 0; i < 40 && !(instr_valid && imem_rvalid); i++) step();
    chk("t5_wait", {31'd0, (instr_valid && imem_rvalid)}, 32'd1);
    instr_ready = 1'b1;
    do_redirect(32'h400);
    chk("t5_empty", {31'd0, instr_valid}, 32'd0);
    n = pop_log.size();
    for (int i = 0; i < 40 && pop_log.size() <= n; i++) step();
    if (pop_log.size() > n) chk("t5_pc", pop_log[n], 32'h400);
    else chk("t5_pop_wait", 32'd0, 32'd1);

    // Asynchronous reset in the middle of a read
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && !(mem_pend && !imem_rvalid); i++) step();
    chk("t6_wait_pend", {31'd0, (mem_pend && !imem_rvalid)}, 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_vals("t6");
    step();
    step();
    rst = 1'b1;
    g = gnt_log.size(); n = pop_log.size();
    for (int i = 0; i < 40 && (gnt_log.size() <= g || pop_log.size() <= n); i++) step();
    chk("t6_wait", {31'd0, (gnt_log.size() > g && pop_log.size() > n)}, 32'd1);
    if (gnt_log.size() > g) chk("t6_addr", gnt_log[g], RESET_PC);
    if (pop_log.size() > n) chk("t6_pc", pop_log[n], RESET_PC);

    // Random traffic, including a PC wrap
    g_prob = 60; lat_min = 1; lat_max = 3;
    do_redirect(32'hFFFF_FFF9);
    for (int i = 0; i < 1500; i++) begin
      redirect_valid = 1'b0;
      instr_ready = (int'($urandom_range(99, 0)) < 70);
      if (int'($urandom_range(99, 0)) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
      step();
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (20) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
